// File: rtl/fetch_decode_buffer.sv
// Two-entry skid buffer between fetch and decode, with PC range checking.
// Optional performance counters are enabled with FETCH_DECODE_BUFFER_PERF_EN.
module fetch_decode_buffer #(
    parameter logic [31:0] NOP_WORD = {6'b111111, 26'b0},
    parameter int unsigned PC_LIMIT = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instrn,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instrn,
    output logic [31:0] out_pc,
    input  logic        flush,
`ifdef FETCH_DECODE_BUFFER_PERF_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic        pc_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] head_instrn_q, head_instrn_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_instrn_q, tail_instrn_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic        pc_err_q, pc_err_d;

    logic push;
    logic pop;
    logic pc_bad;
    logic store;

    // Handshake uses registered state only, so in_ready never depends on out_ready.
    assign push   = in_valid && (state_q != ST_FULL) && !flush;
    assign pop    = (state_q != ST_EMPTY) && out_ready && !flush;
    assign pc_bad = (in_pc >= PC_LIMIT);
    assign store  = push && !pc_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (store) state_d = ST_HALF;
                ST_HALF: begin
                    if (store && !pop)      state_d = ST_FULL;
                    else if (!store && pop) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_HALF;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q != ST_FULL);
        out_valid  = (state_q != ST_EMPTY);
        out_instrn = head_instrn_q;
        out_pc     = head_pc_q;
        pc_err     = pc_err_q;
    end

    // Head is parked at NOP_WORD/0 whenever empty so outputs come straight from flops.
    always_comb begin
        head_instrn_d = head_instrn_q;
        head_pc_d     = head_pc_q;
        tail_instrn_d = tail_instrn_q;
        tail_pc_d     = tail_pc_q;
        pc_err_d      = pc_err_q || (push && pc_bad);
        if (flush) begin
            head_instrn_d = NOP_WORD;
            head_pc_d     = 32'd0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (store) begin
                        head_instrn_d = in_instrn;
                        head_pc_d     = in_pc;
                    end
                end
                ST_HALF: begin
                    if (store && pop) begin
                        head_instrn_d = in_instrn;
                        head_pc_d     = in_pc;
                    end else if (store) begin
                        tail_instrn_d = in_instrn;
                        tail_pc_d     = in_pc;
                    end else if (pop) begin
                        head_instrn_d = NOP_WORD;
                        head_pc_d     = 32'd0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_instrn_d = tail_instrn_q;
                        head_pc_d     = tail_pc_q;
                    end
                end
                default: begin
                    head_instrn_d = NOP_WORD;
                    head_pc_d     = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_instrn_q <= NOP_WORD;
            head_pc_q     <= 32'd0;
            tail_instrn_q <= NOP_WORD;
            tail_pc_q     <= 32'd0;
            pc_err_q      <= 1'b0;
        end else begin
            head_instrn_q <= head_instrn_d;
            head_pc_q     <= head_pc_d;
            tail_instrn_q <= tail_instrn_d;
            tail_pc_q     <= tail_pc_d;
            pc_err_q      <= pc_err_d;
        end
    end

`ifdef FETCH_DECODE_BUFFER_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush && (flush_cnt_q != 16'hFFFF))                 flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed self-checking bench for fetch_decode_buffer using immediate assertions.
`timescale 1ns/1ps
module tb_fetch_decode_buffer;

    localparam logic [31:0] NOP = 32'hFC000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instrn;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instrn;
    logic [31:0] out_pc;
    logic        flush;
    logic        pc_err;
`ifdef FETCH_DECODE_BUFFER_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fetch_decode_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instrn  (in_instrn),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instrn (out_instrn),
        .out_pc     (out_pc),
        .flush      (flush),
`ifdef FETCH_DECODE_BUFFER_PERF_EN
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
`endif
        .pc_err     (pc_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] pc);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_instrn = 32'hA000_0000 | pc;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instrn = 32'd0; in_pc = 32'd0;
        out_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_instrn", out_instrn, NOP);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_pc_err", {31'd0, pc_err}, 32'd0);
        $display("txn reset done");

        // Streaming with out_ready=1: no bubbles
        out_ready = 1'b1;
        offer(32'd0); tick();
        chk("stream_pc0", out_pc, 32'd0);
        chk("stream_instr0", out_instrn, 32'hA000_0000);
        chk("stream_valid0", {31'd0, out_valid}, 32'd1);
        chk("stream_ready0", {31'd0, in_ready}, 32'd1);
        offer(32'd4); tick();
        chk("stream_pc4", out_pc, 32'd4);
        chk("stream_ready4", {31'd0, in_ready}, 32'd1);
        offer(32'd8); tick();
        chk("stream_pc8", out_pc, 32'd8);
        chk("stream_instr8", out_instrn, 32'hA000_0008);
        in_valid = 1'b0; tick();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);
        chk("stream_drained_pc", out_pc, 32'd0);
        $display("txn streaming 0,4,8 done");

        // Backpressure
        out_ready = 1'b0;
        offer(32'd0); tick();
        chk("bp_ready_after1", {31'd0, in_ready}, 32'd1);
        offer(32'd4); tick();
        chk("bp_ready_after2", {31'd0, in_ready}, 32'd0);
        chk("bp_head0", out_pc, 32'd0);
        offer(32'd8); tick();
        chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_held_head", out_pc, 32'd0);
        out_ready = 1'b1; tick();
        chk("bp_drain4", out_pc, 32'd4);
        chk("bp_ready_again", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_drain8", out_pc, 32'd8);
        in_valid = 1'b0; tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        $display("txn backpressure 0,4,8 done");

        // Flush from FULL with an in-flight word
        out_ready = 1'b0;
        offer(32'd16); tick();
        offer(32'd20); tick();
        chk("fl_full", {31'd0, in_ready}, 32'd0);
        chk("fl_head16", out_pc, 32'd16);
        flush = 1'b1; offer(32'd24); tick();
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_instrn", out_instrn, NOP);
        chk("fl_pc", out_pc, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("fl_no24", {31'd0, out_valid}, 32'd0);
        $display("txn flush full 16,20 with 24 done");

        // PC range
        out_ready = 1'b0;
        offer(32'd2048);
        chk("pr_handshake", {31'd0, in_ready}, 32'd1);
        tick();
        chk("pr_not_stored", {31'd0, out_valid}, 32'd0);
        chk("pr_err", {31'd0, pc_err}, 32'd1);
        offer(32'd2044); tick();
        chk("pr_edge_stored", out_pc, 32'd2044);
        offer(32'd4096); tick();
        chk("pr_half_kept", {31'd0, in_ready}, 32'd1);
        chk("pr_half_head", out_pc, 32'd2044);
        in_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0;
        chk("pr_err_sticky", {31'd0, pc_err}, 32'd1);
        chk("pr_flushed", {31'd0, out_valid}, 32'd0);
        $display("txn pc range 2048/2044/4096 done");

        // Simultaneous push and pop in HALF
        out_ready = 1'b0;
        offer(32'd4); tick();
        out_ready = 1'b1; offer(32'd8); tick();
        chk("pp_pc8", out_pc, 32'd8);
        chk("pp_half", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0; tick();
        chk("pp_empty", {31'd0, out_valid}, 32'd0);
        $display("txn push+pop in half done");

        // Reset in FULL
        out_ready = 1'b0;
        offer(32'd100); tick();
        offer(32'd104); tick();
        chk("rf_full", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rf_valid", {31'd0, out_valid}, 32'd0);
        chk("rf_ready", {31'd0, in_ready}, 32'd1);
        chk("rf_pc", out_pc, 32'd0);
        chk("rf_err", {31'd0, pc_err}, 32'd0);
`ifdef FETCH_DECODE_BUFFER_PERF_EN
        chk("rf_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        out_ready = 1'b1; tick();
        chk("rf_no_old", {31'd0, out_valid}, 32'd0);
        $display("txn reset in full done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
